// File: rtl/vector_operand_loader.sv
// Operand-fetch stage: reads two N-bit vectors word by word from a W-bit memory
// and hands the pair to the ALU over a valid/ready handshake.
module vector_operand_loader #(
  parameter int N  = 128,
  parameter int W  = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic          busy,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_rvalid,
  output logic [N-1:0]  op_a,
  output logic [N-1:0]  op_b,
  output logic          op_valid,
  input  logic          op_ready
);

  localparam int BEATS = N / W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WB    = W / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_VALID} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            sel_q, sel_d;
  logic [AW-1:0]   base_a_q, base_a_d;
  logic [AW-1:0]   base_b_q, base_b_d;
  logic [N-1:0]    op_a_q, op_a_d;
  logic [N-1:0]    op_b_q, op_b_d;
  logic            last_beat;

  assign last_beat = (beat_q == BW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      sel_q    <= 1'b0;
      base_a_q <= '0;
      base_b_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      sel_q    <= sel_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end

  // sel_q: 0 = operand A, 1 = operand B
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    sel_d    = sel_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_a_d = addr_a;
          base_b_d = addr_b;
          beat_d   = '0;
          sel_d    = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          if (sel_q) op_b_d[W*beat_q +: W] = mem_rdata;
          else       op_a_d[W*beat_q +: W] = mem_rdata;
          if (!last_beat) begin
            beat_d  = beat_q + BW'(1);
            state_d = S_REQ;
          end else if (!sel_q) begin
            beat_d  = '0;
            sel_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (op_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    mem_req  = (state_q == S_REQ);
    op_valid = (state_q == S_VALID);
    mem_addr = '0;
    if (state_q == S_REQ)
      mem_addr = (sel_q ? base_b_q : base_a_q) + AW'(beat_q) * AW'(WB);
  end

  assign op_a = op_a_q;
  assign op_b = op_b_q;

endmodule

// File: tb/tb_vector_operand_loader.sv
// Self-checking bench for vector_operand_loader with a latency-programmable
// memory model and a word-level reference for addresses and operands.
module tb_vector_operand_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  addr_a = '0;
  logic [31:0]  addr_b = '0;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata = '0;
  logic         mem_rvalid = 1'b0;
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic         op_valid;
  logic         op_ready = 1'b0;

  int total = 0;
  int bad = 0;

  int          mem_lat = 0;
  logic [31:0] mem_salt = '0;
  bit          stray_en = 1'b0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] addr_log[$];

  vector_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_a(addr_a), .addr_b(addr_b),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  // Memory: word at address x is x ^ salt; responds mem_lat cycles after the
  // cycle following the request. Optional junk strobes outside real WAITs.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_addr ^ mem_salt;
        pend       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (mem_req) begin
      pend      = 1'b1;
      pend_cnt  = mem_lat;
      pend_addr = mem_addr;
      addr_log.push_back(mem_addr);
    end
    if (stray_en && !mem_rvalid && (mem_req || !pend)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
  end

  function automatic logic [127:0] ref_vec(input logic [31:0] base, input logic [31:0] salt);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = (base + 32'(4*i)) ^ salt;
    return v;
  endfunction

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    addr_a = a;
    addr_b = b;
    start  = 1'b1;
    addr_log.delete();
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output bit timed_out);
    cyc = 0;
    while (!op_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = !op_valid;
  endtask

  task automatic test_reset();
    total++;
    if ({busy, mem_req, op_valid} !== 3'b000 || mem_addr !== '0 || op_a !== '0 || op_b !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b req=%b valid=%b addr=%h a=%h b=%h want all zero",
               busy, mem_req, op_valid, mem_addr, op_a, op_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || op_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, op_valid);
    end
  endtask

  task automatic test_operation(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input int lat, input int rdly);
    int cyc;
    bit to;
    logic [31:0]  exp_addr, got_addr;
    logic [127:0] exp_a, exp_b;
    mem_lat = lat;
    mem_salt = (nm == "plan" || nm == "waits") ? 32'h0 : $urandom;
    exp_a = ref_vec(a, mem_salt);
    exp_b = ref_vec(b, mem_salt);
    do_start(a, b);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_after_start: got %b want 1", nm, busy);
    end
    wait_valid(cyc, to);
    total++;
    if (to || cyc != 16 + 8*lat) begin
      bad++;
      $display("FAIL %s latency: got %0d edges (timeout=%0d) want %0d", nm, cyc, to, 16 + 8*lat);
    end
    total++;
    if (addr_log.size() != 8) begin
      bad++;
      $display("FAIL %s req_count: got %0d want 8", nm, addr_log.size());
    end
    for (int i = 0; i < 8; i++) begin
      exp_addr = (i < 4) ? a + 32'(4*i) : b + 32'(4*(i-4));
      got_addr = (i < addr_log.size()) ? addr_log[i] : 32'hxxxx_xxxx;
      total++;
      if (got_addr !== exp_addr) begin
        bad++;
        $display("FAIL %s mem_addr[%0d]: got %h want %h", nm, i, got_addr, exp_addr);
      end
    end
    for (int k = 0; k <= rdly; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (op_valid !== 1'b1 || op_a !== exp_a || op_b !== exp_b) begin
        bad++;
        $display("FAIL %s hold[%0d]: valid=%b a=%h b=%h want 1 a=%h b=%h",
                 nm, k, op_valid, op_a, op_b, exp_a, exp_b);
      end
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    total++;
    if (op_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s handshake: valid=%b busy=%b want 0 0", nm, op_valid, busy);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit to;
    logic [31:0] a1, b1, a2, b2;
    a1 = 32'h0000_1000; b1 = 32'h0000_2000;
    a2 = 32'h0000_3000; b2 = 32'h0000_4000;
    mem_lat = 2;
    mem_salt = $urandom;
    do_start(a1, b1);
    @(negedge clk);
    addr_a = 32'hDEAD_0000;
    addr_b = 32'hBEEF_0000;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_valid(cyc, to);
    total++;
    if (to || addr_log.size() != 8 || addr_log[0] !== a1 || addr_log[4] !== b1) begin
      bad++;
      $display("FAIL ign_wait_addr: size=%0d first=%h fifth=%h want 8 %h %h",
               addr_log.size(), addr_log.size() > 0 ? addr_log[0] : 32'h0,
               addr_log.size() > 4 ? addr_log[4] : 32'h0, a1, b1);
    end
    total++;
    if (op_a !== ref_vec(a1, mem_salt) || op_b !== ref_vec(b1, mem_salt)) begin
      bad++;
      $display("FAIL ign_wait_ops: a=%h b=%h want a=%h b=%h", op_a, op_b,
               ref_vec(a1, mem_salt), ref_vec(b1, mem_salt));
    end
    op_ready = 1'b1;
    start    = 1'b1;
    addr_a   = a2;
    addr_b   = b2;
    addr_log.delete();
    @(negedge clk);
    op_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || op_valid !== 1'b0) begin
      bad++;
      $display("FAIL ign_valid_start: busy=%b valid=%b want 0 0", busy, op_valid);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL accept_next_start: busy=%b want 1", busy);
    end
    wait_valid(cyc, to);
    total++;
    if (to || addr_log.size() != 8 || addr_log[0] !== a2 || addr_log[7] !== b2 + 32'hC) begin
      bad++;
      $display("FAIL second_op_addr: timeout=%0d size=%0d want 8 from %h/%h", to, addr_log.size(), a2, b2);
    end
    total++;
    if (op_a !== ref_vec(a2, mem_salt) || op_b !== ref_vec(b2, mem_salt)) begin
      bad++;
      $display("FAIL second_op_ops: a=%h b=%h want a=%h b=%h", op_a, op_b,
               ref_vec(a2, mem_salt), ref_vec(b2, mem_salt));
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    int n;
    mem_lat = 4;
    mem_salt = $urandom;
    do_start(32'h0000_5000, 32'h0000_6000);
    n = 0;
    while (addr_log.size() < 7 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (addr_log.size() < 7) begin
      bad++;
      $display("FAIL midop_reach: got %0d requests want 7", addr_log.size());
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, mem_req, op_valid} !== 3'b000 || mem_addr !== '0 || op_a !== '0 || op_b !== '0) begin
      bad++;
      $display("FAIL midop_reset_outputs: busy=%b req=%b valid=%b addr=%h a=%h b=%h want zeros",
               busy, mem_req, op_valid, mem_addr, op_a, op_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (busy !== 1'b0 || op_valid !== 1'b0 || op_a !== '0 || op_b !== '0) begin
      bad++;
      $display("FAIL late_response: busy=%b valid=%b a=%h b=%h want 0 0 0 0", busy, op_valid, op_a, op_b);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_operation("plan", 32'h0000_0100, 32'h0000_0200, 0, 0);
    test_operation("waits", 32'h0000_0100, 32'h0000_0200, 3, 5);
    test_start_ignored();
    test_operation("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFF4, 1, 1);
    stray_en = 1'b1;
    test_operation("stray", $urandom, $urandom, 1, 3);
    stray_en = 1'b0;
    for (int r = 0; r < 6; r++)
      test_operation("random", $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    test_reset_midop();
    test_operation("recover", $urandom, $urandom, 0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
